demux_packet_steer: RTL and testbench

- Upstream feeder for the 1:2 byte demux.
- Accepts a valid/ready byte stream framed as packets: one header byte followed by payload bytes.
- Drives the demux data bus and select line from a registered output stage, and presents per-lane valid/ready handshakes to the two lane consumers.
- Packets with malformed headers are consumed and discarded, never forwarded.

---
 rtl/demux_packet_steer.sv | 133 +++++++++++++
 tb/tb_demux_packet_steer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_packet_steer.sv
`default_nettype none
// ============================================================================
//  Module      : demux_packet_steer
//  Description : Packet-framed byte feeder for a 1:2 byte demux. Parses a
//                header byte (lane + length), forwards the payload through a
//                one-entry registered output stage with per-lane handshakes,
//                and discards packets whose header has reserved bits set.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_packet_steer #(
  parameter int LEN_W      = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            data,
  output logic                  sel,
  output logic [1:0]            lane_valid,
  input  logic [1:0]            lane_ready,
  output logic                  pkt_done,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_pkt_sel;
  logic [7:0]            r_data;
  logic                  r_out_sel;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_pkt_done;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic w_xfer;
  logic w_ds_xfer;
  logic w_load;
  logic w_cnt_zero;
  logic w_rsvd_err;

  // Payload may only be accepted when the output register is free or
  // draining this cycle; header and discarded bytes never touch it.
  assign in_ready   = (r_state != S_PAYLOAD) | ~r_out_valid | lane_ready[r_out_sel];
  assign w_xfer     = in_valid & in_ready;
  assign w_ds_xfer  = r_out_valid & lane_ready[r_out_sel];
  assign w_load     = w_xfer & (r_state == S_PAYLOAD);
  assign w_cnt_zero = (r_cnt == '0);
  // Reserved header bits sit between the lane bit and the length field.
  assign w_rsvd_err = |in_data[6:LEN_W];

  assign data       = r_data;
  assign sel        = r_out_sel;
  assign lane_valid = {r_out_valid & r_out_sel, r_out_valid & ~r_out_sel};
  assign pkt_done   = r_pkt_done;
  assign drop_cnt   = r_drop_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: header selects forward or discard, length count ends packet.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR:     if (w_xfer) w_state_nxt = w_rsvd_err ? S_DROP : S_PAYLOAD;
      S_PAYLOAD: if (w_xfer && w_cnt_zero) w_state_nxt = S_HDR;
      S_DROP:    if (w_xfer && w_cnt_zero) w_state_nxt = S_HDR;
      default:   w_state_nxt = S_HDR;
    endcase
  end

  // Header capture and remaining-byte counter (holds while in_valid is low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pkt_sel <= 1'b0;
    end else if (w_xfer) begin
      if (r_state == S_HDR) begin
        r_cnt     <= in_data[LEN_W-1:0];
        r_pkt_sel <= in_data[7];
      end else begin
        r_cnt     <= r_cnt - 1'b1;
      end
    end
  end

  // One-entry output register; a load in the same cycle as a drain refills
  // without a bubble. The lane travels with the byte, so a later header
  // cannot retarget a byte still waiting here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= 8'd0;
      r_out_sel   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_data      <= in_data;
      r_out_sel   <= r_pkt_sel;
      r_out_valid <= 1'b1;
      r_out_last  <= w_cnt_zero;
    end else if (w_ds_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the last payload byte leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pkt_done <= 1'b0;
    else     r_pkt_done <= w_ds_xfer & r_out_last;
  end

  // Saturating count of discarded packets, bumped on a dropped packet's last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if ((r_state == S_DROP) && w_xfer && w_cnt_zero && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_packet_steer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_packet_steer
//  Description : Self-checking bench for demux_packet_steer. Builds packet
//                streams, predicts the forwarded byte sequence, lanes,
//                completion pulses and drop count from the packet list.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_packet_steer;

  localparam int LEN_W      = 4;
  localparam int DROP_CNT_W = 8;
  localparam int MAX_CYC    = 20000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            data;
  logic                  sel;
  logic [1:0]            lane_valid;
  logic [1:0]            lane_ready;
  logic                  pkt_done;
  logic [DROP_CNT_W-1:0] drop_cnt;

  demux_packet_steer #(
    .LEN_W      (LEN_W),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .sel        (sel),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .pkt_done   (pkt_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic       sel;
    logic [7:0] data;
  } out_t;

  // Input stream: byte and its role (0 header, 1 forwarded payload, 2 dropped payload).
  logic [7:0] s_byte[$];
  int         s_kind[$];
  // Forwarded bytes in the order they must leave the block.
  out_t       exp_q[$];
  int         exp_drops = 0;
  int         inflight  = 0;
  bit         pend_done = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Append one packet; base!=0 gives payload base, base+1, ...
  function automatic void add_pkt(input bit bad, input bit lane, input int len, input int base);
    logic [7:0] h;
    logic [7:0] b;
    logic [2:0] r;
    r = bad ? 3'($urandom_range(1, 7)) : 3'd0;
    h = {lane, r, 4'(len - 1)};
    s_byte.push_back(h);
    s_kind.push_back(0);
    for (int i = 0; i < len; i++) begin
      b = (base != 0) ? 8'(base + i) : 8'($urandom);
      s_byte.push_back(b);
      s_kind.push_back(bad ? 2 : 1);
      if (!bad) exp_q.push_back({(i == len - 1), lane, b});
    end
    if (bad) exp_drops++;
  endfunction

  // Drive the queued stream with random valid/ready and check every cycle.
  task automatic run_stream(input int vprob, input int rprob);
    int   cyc;
    bit   acc;
    bit   ds;
    bit   nxt_done;
    bit   exp_rdy;
    out_t o;
    cyc = 0;
    o   = '0;
    while (cyc < MAX_CYC) begin
      if (s_byte.size() == 0 && inflight == 0 && !pend_done) break;
      in_valid   = (s_byte.size() > 0) && ($urandom_range(0, 99) < vprob);
      in_data    = in_valid ? s_byte[0] : 8'($urandom);
      lane_ready = {1'($urandom_range(0, 99) < rprob), 1'($urandom_range(0, 99) < rprob)};
      @(negedge clk);
      check_eq("pkt_done", pkt_done, pend_done);
      check_eq("out_valid", |lane_valid, inflight != 0);
      if (inflight != 0) begin
        o = exp_q[0];
        check_eq("lane_valid", lane_valid, o.sel ? 2 : 1);
        check_eq("sel", sel, o.sel);
        check_eq("data", data, o.data);
      end
      if (s_byte.size() > 0) begin
        exp_rdy = (s_kind[0] != 1) || (inflight == 0) || lane_ready[o.sel];
        check_eq("in_ready", in_ready, exp_rdy);
      end
      acc      = in_valid && in_ready;
      ds       = (inflight != 0) && lane_ready[o.sel];
      nxt_done = 1'b0;
      if (ds) begin
        void'(exp_q.pop_front());
        inflight--;
        nxt_done = o.last;
      end
      if (acc) begin
        if (s_kind[0] == 1) inflight++;
        void'(s_byte.pop_front());
        void'(s_kind.pop_front());
      end
      pend_done = nxt_done;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= MAX_CYC) check_eq("timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    lane_ready = 2'b00;
    #1;
    check_eq("rst_data", data, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_lane_valid", lane_valid, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Lane 0, three bytes, full throughput.
    add_pkt(0, 0, 3, 'hA1);
    run_stream(100, 100);
    // Lane 1 single byte under back-pressure.
    add_pkt(0, 1, 1, 'h55);
    run_stream(100, 30);
    // Back-to-back single-byte packets on alternating lanes.
    add_pkt(0, 0, 1, 'h11);
    add_pkt(0, 1, 1, 'h22);
    run_stream(100, 100);
    // Malformed header then a good packet.
    add_pkt(1, 0, 4, 0);
    add_pkt(0, 0, 1, 'h77);
    run_stream(100, 100);
    check_eq("drop_cnt_one", drop_cnt, 1);

    // Random mixes of good and bad packets, lengths 1..16.
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 15; p++)
        add_pkt($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), $urandom_range(1, 16), 0);
      run_stream(40 + r * 12, 30 + r * 12);
      check_eq("drop_cnt_rand", drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
    end

    // Reset in the middle of a 5-byte packet with a byte held in the output.
    s_byte.push_back(8'h04); s_kind.push_back(0);
    s_byte.push_back(8'hC1); s_kind.push_back(1); exp_q.push_back({1'b0, 1'b0, 8'hC1});
    s_byte.push_back(8'hC2); s_kind.push_back(1); exp_q.push_back({1'b0, 1'b0, 8'hC2});
    run_stream(100, 100);
    in_valid   = 1'b1;
    in_data    = 8'h33;
    lane_ready = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_lane_valid", lane_valid, 2'b01);
    check_eq("mid_data", data, 8'h33);
    rst = 1'b1;
    #1;
    check_eq("rstmid_lane_valid", lane_valid, 0);
    check_eq("rstmid_pkt_done", pkt_done, 0);
    check_eq("rstmid_drop_cnt", drop_cnt, 0);
    s_byte.delete();
    s_kind.delete();
    exp_q.delete();
    inflight  = 0;
    pend_done = 0;
    exp_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_pkt_done", pkt_done, 0);
    // 0x81: lane 1, two bytes.
    add_pkt(0, 1, 2, 'h90);
    run_stream(100, 100);
    check_eq("post_rst_drop_cnt", drop_cnt, 0);

    // Saturation of the drop counter.
    for (int p = 0; p < 260; p++)
      add_pkt(1, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 0);
    run_stream(100, 100);
    check_eq("drop_cnt_sat", drop_cnt, 255);
    add_pkt(0, 0, 2, 'hE0);
    run_stream(100, 100);
    check_eq("drop_cnt_sat_hold", drop_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
